// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings, port ids,
// default widths and the access-legality check.
package dm_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;

    // Word-aligned and inside the decoded window, otherwise rejected.
    function automatic logic addr_bad(input logic [31:0] addr, input int addr_w);
        return (addr[1:0] != 2'b00) || ((addr >> addr_w) != 32'd0);
    endfunction

endpackage

// File: rtl/dm_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a sole requester always wins,
// on a tie the pointer decides.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o
);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch is inferred.
        grant_id_o = 1'b0;
        grant_o    = 2'b00;
        case (req_i)
            2'b01:   grant_id_o = 1'b0;
            2'b10:   grant_id_o = 1'b1;
            2'b11:   grant_id_o = ptr_i;
            default: grant_id_o = 1'b0;
        endcase
        if (req_i != 2'b00) begin
            grant_o = grant_id_o ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates the single-port data memory between the CPU (port 0) and the
// loader/debug port (port 1): latch, drive memory one cycle, ack with data.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int   ADDR_W   = DEF_ADDR_W,
    parameter int   DATA_W   = DEF_DATA_W,
    parameter logic PTR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [31:0]       pc0,
    input  logic [31:0]       pc1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic [31:0]       mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    output logic [31:0]       mem_pc,
    input  logic [DATA_W-1:0] mem_rd
);

    logic [1:0]        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic              bad_q, bad_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       pc_q, pc_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0]        grant;
    logic              grant_id;

    rr_pick2 u_pick (
        .req_i      ({req1, req0}),
        .ptr_i      (ptr_q),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        we_d    = we_q;
        bad_d   = bad_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    owner_d = grant_id;
                    if (grant_id == PORT_DBG) begin
                        we_d    = we1;
                        addr_d  = addr1;
                        wdata_d = wdata1;
                        pc_d    = pc1;
                    end else begin
                        we_d    = we0;
                        addr_d  = addr0;
                        wdata_d = wdata0;
                        pc_d    = pc0;
                    end
                    bad_d   = addr_bad(addr_d, ADDR_W);
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                rdata_d = bad_q ? '0 : mem_rd;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // Hand the next tie to the port that just waited.
                ptr_d   = ~owner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_INIT;
            owner_q <= PORT_CPU;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            addr_q  <= '0;
            pc_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Decoded from state so an async reset drops the write strobe at once.
    assign mem_we = (state_q == ST_ACCESS) && we_q && !bad_q;
    assign mem_a  = addr_q;
    assign mem_wd = wdata_q;
    assign mem_pc = pc_q;
    assign rdata  = rdata_q;

    assign ack0 = (state_q == ST_DONE) && (owner_q == PORT_CPU);
    assign ack1 = (state_q == ST_DONE) && (owner_q == PORT_DBG);
    assign err0 = ack0 && bad_q;
    assign err1 = ack1 && bad_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a word-indexed memory model behind it.
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_v;
    logic [1:0]  we_v;
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic [31:0] pc_v    [2];

    logic        ack0, ack1, err0, err1, mem_we;
    logic [31:0] rdata, mem_a, mem_wd, mem_pc, mem_rd;

    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;
    int we_cycles = 0;

    dm_arbiter #(.ADDR_W(12), .DATA_W(32), .PTR_INIT(1'b0)) dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req_v[0]),
        .req1   (req_v[1]),
        .we0    (we_v[0]),
        .we1    (we_v[1]),
        .addr0  (addr_v[0]),
        .addr1  (addr_v[1]),
        .wdata0 (wdata_v[0]),
        .wdata1 (wdata_v[1]),
        .pc0    (pc_v[0]),
        .pc1    (pc_v[1]),
        .ack0   (ack0),
        .ack1   (ack1),
        .err0   (err0),
        .err1   (err1),
        .rdata  (rdata),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_we (mem_we),
        .mem_pc (mem_pc),
        .mem_rd (mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            mem[mem_a[11:2]] <= mem_wd;
            we_cycles++;
        end
    end
    assign mem_rd = mem[mem_a[11:2]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] mask(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic drive(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_v[p]   = 1'b1;
        we_v[p]    = w;
        addr_v[p]  = a;
        wdata_v[p] = d;
        pc_v[p]    = 32'h0000_8000 + a;
    endtask

    // One uncontended access starting this cycle; returns at t+3 with req dropped.
    task automatic single(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd,
                          input string tag);
        int base;
        logic exp_we;
        base   = we_cycles;
        exp_we = w & ~exp_err;
        drive(p, w, a, d);
        step();
        check({tag, "/ack_early"}, {ack1, ack0}, 2'b00);
        check({tag, "/mem_we"}, mem_we, exp_we);
        check({tag, "/mem_a"}, mem_a, a);
        check({tag, "/mem_pc"}, mem_pc, 32'h0000_8000 + a);
        if (w) check({tag, "/mem_wd"}, mem_wd, d);
        step();
        check({tag, "/ack"}, {ack1, ack0}, mask(p));
        check({tag, "/err"}, {err1, err0}, exp_err ? mask(p) : 2'b00);
        check({tag, "/we_off"}, mem_we, 1'b0);
        if (chk_rd) check({tag, "/rdata"}, rdata, exp_rd);
        step();
        req_v[p] = 1'b0;
        check({tag, "/we_count"}, we_cycles - base, exp_we ? 1 : 0);
    endtask

    // Both ports request in the same cycle; w is the expected winner.
    task automatic pair(input int w, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                        input logic chk, input logic [31:0] rd0, input logic [31:0] rd1,
                        input string tag);
        int l;
        l = 1 - w;
        drive(0, w0, a0, d0);
        drive(1, w1, a1, d1);
        step();
        check({tag, "/first_a"}, mem_a, (w == 0) ? a0 : a1);
        check({tag, "/first_we"}, mem_we, (w == 0) ? w0 : w1);
        check({tag, "/no_ack"}, {ack1, ack0}, 2'b00);
        step();
        check({tag, "/first_ack"}, {ack1, ack0}, mask(w));
        if (chk) check({tag, "/first_rd"}, rdata, (w == 0) ? rd0 : rd1);
        step();
        req_v[w] = 1'b0;
        check({tag, "/gap"}, {ack1, ack0}, 2'b00);
        step();
        check({tag, "/second_a"}, mem_a, (l == 0) ? a0 : a1);
        step();
        check({tag, "/second_ack"}, {ack1, ack0}, mask(l));
        if (chk) check({tag, "/second_rd"}, rdata, (l == 0) ? rd0 : rd1);
        step();
        req_v[l] = 1'b0;
    endtask

    initial begin
        int base;
        req_v = 2'b00;
        we_v  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr_v[i]  = '0;
            wdata_v[i] = '0;
            pc_v[i]    = '0;
        end
        repeat (2) step();

        check("rst/ack", {ack1, ack0}, 2'b00);
        check("rst/err", {err1, err0}, 2'b00);
        check("rst/mem_we", mem_we, 1'b0);
        check("rst/rdata", rdata, 32'h0);
        check("rst/mem_a", mem_a, 32'h0);
        check("rst/mem_wd", mem_wd, 32'h0);
        check("rst/mem_pc", mem_pc, 32'h0);
        check("rst/state", dut.state_q, ST_IDLE);
        check("rst/ptr", dut.ptr_q, 1'b0);
        reset = 1'b1;
        step();

        // Tie from reset: port 0 at t+2, port 1 at t+5; pointer returns to 0.
        pair(0, 1'b1, 32'h20, 32'h1111_1111, 1'b1, 32'h24, 32'h2222_2222,
             1'b0, 32'h0, 32'h0, "tie_wr");
        pair(0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h24, 32'h0,
             1'b1, 32'h1111_1111, 32'h2222_2222, "tie_rd");

        single(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, "wr10");
        single(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, "rd10");

        // Port 0 was served last, so port 1 now wins the tie.
        pair(1, 1'b0, 32'h24, 32'h0, 1'b0, 32'h20, 32'h0,
             1'b1, 32'h2222_2222, 32'h1111_1111, "tie_alt");

        // Reset during the ACCESS cycle of a write.
        base = we_cycles;
        drive(0, 1'b1, 32'h40, 32'hCAFE_F00D);
        step();
        check("abort/we_before", mem_we, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("abort/we_drop", mem_we, 1'b0);
        check("abort/ack", {ack1, ack0}, 2'b00);
        check("abort/state", dut.state_q, ST_IDLE);
        check("abort/ptr", dut.ptr_q, 1'b0);
        req_v[0] = 1'b0;
        step();
        check("abort/ack_late", {ack1, ack0}, 2'b00);
        check("abort/no_write", we_cycles - base, 0);
        reset = 1'b1;
        step();
        check("abort/idle_ack", {ack1, ack0}, 2'b00);
        single(0, 1'b1, 32'h40, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, "reissue");
        single(0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, "reissue_rd");

        // Rejected accesses and the last legal word.
        single(1, 1'b1, 32'h13, 32'h5555_5555, 1'b1, 1'b1, 32'h0, "misalign");
        single(1, 1'b1, 32'h1000, 32'h6666_6666, 1'b1, 1'b1, 32'h0, "range");
        single(1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1, 32'h2222_2222, "legal_rd");
        single(1, 1'b0, 32'h1024, 32'h0, 1'b1, 1'b1, 32'h0, "range_rd");
        single(1, 1'b1, 32'hFFC, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0, "top_wr");
        single(0, 1'b0, 32'hFFC, 32'h0, 1'b0, 1'b1, 32'hA5A5_A5A5, "top_rd");

        // Port 0 streams; port 1 arrives mid-access and goes next.
        drive(0, 1'b0, 32'h20, 32'h0);
        step();
        drive(1, 1'b1, 32'h30, 32'h3333_3333);
        check("stream/a0_access", mem_a, 32'h20);
        step();
        check("stream/ack_a0", {ack1, ack0}, 2'b01);
        check("stream/rd_a0", rdata, 32'h1111_1111);
        step();
        drive(0, 1'b0, 32'h24, 32'h0);
        step();
        check("stream/p1_a", mem_a, 32'h30);
        check("stream/p1_we", mem_we, 1'b1);
        step();
        check("stream/ack_p1", {ack1, ack0}, 2'b10);
        check("stream/err_p1", {err1, err0}, 2'b00);
        step();
        req_v[1] = 1'b0;
        step();
        check("stream/a1_access", mem_a, 32'h24);
        check("stream/a1_we", mem_we, 1'b0);
        step();
        check("stream/ack_a1", {ack1, ack0}, 2'b01);
        check("stream/rd_a1", rdata, 32'h2222_2222);
        step();
        req_v[0] = 1'b0;
        step();
        check("stream/idle", {ack1, ack0}, 2'b00);
        single(0, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1, 32'h3333_3333, "stream_chk");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
